result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Downstream stage of the square32 shift-register/compressor harness.
- Captures the 38 single-bit compressor outputs (dst0..dst37) as one parallel word on request.
- Shifts the word out serially, LSB (dst0) first, over a valid/ready handshake so an external checker can read it through few pins.
- Optionally folds each captured word into a running signature for on-chip self-check.

Parameters:
- WIDTH, 38, number of result bits (dst0..dst{WIDTH-1}).
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W >= WIDTH.
- SIG_W, 16, signature width (used only with SIGNATURE_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- dst_in  input  WIDTH  compressor outputs concatenated; bit i = dst{i}.
- capture  input  1  request to latch dst_in; honoured only in IDLE.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  consumer accepts the bit when high together with sout_valid.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse after the last bit is accepted.
- signature  output  SIG_W  running signature; present only with SIGNATURE_EN.

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. No other clock or reset.
- Reset values: state=IDLE, shift register=0, bit counter=0. sout=0, sout_valid=0, busy=0, done=0, signature=0.
- Reset mid-operation aborts the transfer immediately. No partial word is resumed.
- FSM states:
  - IDLE: capture=1 at edge N latches dst_in into the shift register, clears the counter, and moves to SHIFT. From cycle N+1, sout_valid=1 and sout=dst_in[0].
  - SHIFT: a handshake (sout_valid & sout_ready) at an edge shifts the register right by one and increments the counter.
    - sout always equals the register LSB.
    - sout_ready=0 stalls; sout and sout_valid hold.
    - The handshake with counter==WIDTH-1 moves to DONE; sout_valid drops the same edge.
  - DONE: done=1 for exactly one cycle, busy=1, then IDLE unconditionally.
- capture outside IDLE, including the DONE cycle, is ignored. It is not queued.
- capture and sout_ready have no interaction. sout_ready in IDLE or DONE is ignored.
- Minimum transfer with sout_ready tied high:
  - 1 capture edge, then WIDTH shift cycles, then 1 DONE cycle.
  - Next capture is accepted WIDTH+2 cycles after the previous one.
- dst_in is sampled only at the capture edge. Later changes do not affect an ongoing transfer.
- Counter never exceeds WIDTH-1. No wrap-around inside a transfer.

Optional Feature:
- Macro: RESULT_SERIALIZER_SIGNATURE_EN.
- Defined:
  - On each accepted capture edge, fold = XOR of dst_in split into SIG_W-bit chunks, the top chunk zero-padded.
  - signature <= rotate_left(signature, 1) ^ fold.
  - Reset clears it to 0. Serial timing is unchanged.
- Undefined: the signature port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package result_serializer_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - default constants WIDTH=38, CNT_W=6, SIG_W=16;
  - a fold function (XOR of SIG_W-bit chunks).
- One sub-module, result_sig_accum: the signature register and rotate/XOR update, enabled by a capture-accept strobe. Instantiated only under the macro.

Test Plan:
- Reset then idle with capture=0 → sout_valid=0, busy=0, done=0, sout=0 indefinitely.
- dst_in=38'h2A_0000_0005, capture pulse, sout_ready=1:
  - sout sequence bit0..bit3 = 1,0,1,0; bits 33,35,37 = 1; all others 0.
  - sout_valid high exactly 38 cycles; done pulse on the following cycle; busy high 39 cycles.
- Same word with sout_ready toggled 1,0,1,0…:
  - each bit held stable while ready=0;
  - 38 handshakes total; done after 76 cycles of SHIFT.
- capture re-asserted during SHIFT and on the DONE cycle → ignored, no second transfer. Capture on the first IDLE cycle → new transfer starts.
- rst_n asserted asynchronously at bit 20:
  - all outputs reach 0 immediately;
  - after release, a capture of 38'h3F_FFFF_FFFF shifts 38 ones.
- With RESULT_SERIALIZER_SIGNATURE_EN: two captures of 38'h1 from reset → signature 0x0001 then 0x0003. Capture of 38'h1_0000 → fold = 0x0001.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared types and constants for the result serializer.
// Holds the FSM state encoding, default sizing constants and the
// chunk-XOR fold used by the optional signature accumulator.
package result_serializer_pkg;

  localparam int WIDTH_DEF = 38;
  localparam int CNT_W_DEF = 6;
  localparam int SIG_W_DEF = 16;
  // Fold input is zero-extended to this width; zero chunks do not change
  // the XOR, so any WIDTH up to this value folds correctly.
  localparam int FOLD_IN_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // XOR of consecutive SIG_W_DEF-bit chunks; the top chunk is zero-padded.
  function automatic logic [SIG_W_DEF-1:0] fold(input logic [FOLD_IN_W-1:0] d);
    logic [SIG_W_DEF-1:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_IN_W / SIG_W_DEF; i++) begin
      acc = acc ^ d[i*SIG_W_DEF +: SIG_W_DEF];
    end
    return acc;
  endfunction

endpackage

// File: rtl/result_sig_accum.sv
// Running signature register: sig <= rotl(sig, 1) ^ fold on each enable.
// Ports: clk_i, rst_ni (async active-low), en_i (capture-accept strobe),
//        fold_i (folded captured word), sig_o (current signature).
module result_sig_accum #(
  parameter int SIG_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [SIG_W-1:0] fold_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ fold_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/result_serializer.sv
// Captures a WIDTH-bit result word and shifts it out LSB first over valid/ready.
// Ports: clk, rst_n (async active-low), dst_in/capture (parallel load request),
//        sout/sout_valid/sout_ready (serial handshake), busy, done,
//        signature (only with RESULT_SERIALIZER_SIGNATURE_EN defined).
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef RESULT_SERIALIZER_SIGNATURE_EN
  ,
  parameter int SIG_W = SIG_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dst_in,
  input  logic             capture,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
`ifdef RESULT_SERIALIZER_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] signature
`endif
);

  if ((2 ** CNT_W) < WIDTH) begin : g_cnt_too_narrow
    $error("CNT_W too small for WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_acc;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    cap_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          shreg_d = dst_in;
          cnt_d   = '0;
          cap_acc = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          // Zero fills from the top, so the register is empty (sout=0)
          // once the whole word has been sent.
          shreg_d = shreg_q >> 1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registers so reset clears them at once.
  assign sout       = shreg_q[0];
  assign sout_valid = (state_q == SHIFT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

`ifdef RESULT_SERIALIZER_SIGNATURE_EN
  logic [SIG_W-1:0] fold_val;

  if (WIDTH > FOLD_IN_W) begin : g_fold_too_wide
    $error("WIDTH exceeds fold input width");
  end

  assign fold_val = SIG_W'(fold({{(FOLD_IN_W - WIDTH){1'b0}}, dst_in}));

  result_sig_accum #(
    .SIG_W (SIG_W)
  ) u_sig_accum (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (cap_acc),
    .fold_i (fold_val),
    .sig_o  (signature)
  );
`else
  logic unused_cap_acc;
  assign unused_cap_acc = cap_acc;
`endif

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;

  localparam int W = 38;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  dst_in;
  logic          capture;
  logic          sout;
  logic          sout_valid;
  logic          sout_ready;
  logic          busy;
  logic          done;
`ifdef RESULT_SERIALIZER_SIGNATURE_EN
  logic [15:0]   signature;
`endif

  result_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dst_in     (dst_in),
    .capture    (capture),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .busy       (busy),
    .done       (done)
`ifdef RESULT_SERIALIZER_SIGNATURE_EN
    ,
    .signature  (signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  int valid_cyc, busy_cyc, done_cnt, hs_cnt, idle_bad;
  logic prev_stall, prev_sout;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge; a bit is consumed at the next
  // rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(sout_valid), 64'd1);
        chk("stall_bit_hold", 64'(sout), 64'(prev_sout));
      end
      if (sout_valid && sout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 64'd1, 64'd0);
        end else begin
          chk("sout_bit", 64'(sout), 64'(exp_q.pop_front()));
        end
        hs_cnt++;
      end
      valid_cyc += int'(sout_valid);
      busy_cyc  += int'(busy);
      done_cnt  += int'(done);
      prev_stall = sout_valid && !sout_ready;
      prev_sout  = sout;
    end
  end

  // Starts a transfer in the current (IDLE) cycle and runs it to completion.
  // hold keeps capture asserted through SHIFT and DONE; toggle drives ready
  // 1 on the capture cycle then 0,1,0,... through SHIFT.
  task automatic run_xfer(input logic [W-1:0] word, input bit toggle, input bit hold,
                          input int exp_valid, input int exp_busy);
    int  n;
    bit  ended;
    for (int i = 0; i < W; i++) exp_q.push_back(word[i]);
    valid_cyc = 0; busy_cyc = 0; done_cnt = 0; hs_cnt = 0;
    dst_in     = word;
    capture    = 1'b1;
    sout_ready = 1'b1;
    @(posedge clk); #1;
    capture    = hold;
    dst_in     = ~word;
    sout_ready = toggle ? 1'b0 : 1'b1;
    chk("first_bit_valid", 64'(sout_valid), 64'd1);
    chk("first_bit_value", 64'(sout), 64'(word[0]));
    ended = 1'b0;
    n = 0;
    while (!ended && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (toggle) sout_ready = ~sout_ready;
      if (done) ended = 1'b1;
    end
    chk("xfer_timeout", 64'(ended), 64'd1);
    @(posedge clk); #1;
    chk("back_to_idle_busy", 64'(busy), 64'd0);
    capture = 1'b0;
    chk("valid_cycles", 64'(valid_cyc), 64'(exp_valid));
    chk("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
    chk("handshakes", 64'(hs_cnt), 64'd38);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    capture    = 1'b0;
    sout_ready = 1'b0;
    dst_in     = '0;
    prev_stall = 1'b0;
    prev_sout  = 1'b0;
    #2;
    chk("reset_sout_valid", 64'(sout_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sout", 64'(sout), 64'd0);
    do_reset();

    // Idle with capture low, ready toggling: nothing may come out.
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      sout_ready = ~sout_ready;
      @(negedge clk);
      idle_bad += int'(sout_valid) + int'(busy) + int'(done) + int'(sout);
      @(posedge clk); #1;
    end
    chk("idle_quiet", 64'(idle_bad), 64'd0);

    // Plain transfer: bits 0,2,33,35,37 set.
    run_xfer(38'h2A_0000_0005, 1'b0, 1'b0, 38, 39);
    // Ready alternating: 76 SHIFT cycles, bits held while stalled.
    run_xfer(38'h2A_0000_0005, 1'b1, 1'b0, 76, 77);
    // Capture held high through SHIFT and DONE: must not restart.
    run_xfer(38'h15_5555_5555, 1'b0, 1'b1, 38, 39);
    // Capture on the very first IDLE cycle after a transfer.
    run_xfer(38'h00_F0F0_0F0F, 1'b0, 1'b0, 38, 39);

    // Abort at bit 20 with asynchronous reset.
    for (int i = 0; i < 20; i++) exp_q.push_back(1'b1);
    dst_in     = 38'h3F_FFFF_FFFF;
    capture    = 1'b1;
    sout_ready = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("pre_abort_sout", 64'(sout), 64'd1);
    chk("pre_abort_queue", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_sout", 64'(sout), 64'd0);
    chk("abort_valid", 64'(sout_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_idle", 64'(sout_valid), 64'd0);
    run_xfer(38'h3F_FFFF_FFFF, 1'b0, 1'b0, 38, 39);

`ifdef RESULT_SERIALIZER_SIGNATURE_EN
    do_reset();
    chk("sig_reset", 64'(signature), 64'h0);
    run_xfer(38'h1, 1'b0, 1'b0, 38, 39);
    chk("sig_first", 64'(signature), 64'h0001);
    run_xfer(38'h1, 1'b0, 1'b0, 38, 39);
    chk("sig_second", 64'(signature), 64'h0003);
    do_reset();
    run_xfer(38'h1_0000, 1'b0, 1'b0, 38, 39);
    chk("sig_fold_chunk1", 64'(signature), 64'h0001);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
